// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM with retired-instruction counter
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        PCWrite,
    output logic [1:0]  PCSel,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        ExtOp,
    output logic [2:0]  ALUControl,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXEC_R = 4'd6, RWB = 4'd7, EXEC_I = 4'd8, IWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11
    } state_t;
    typedef enum logic [3:0] {
        K_ILL, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL
    } kind_t;
    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [31:0] retired_q, retired_d;
    assign kind_d = (op == 6'b000000 && funct == 6'b100001) ? K_ADDU :
                    (op == 6'b000000 && funct == 6'b100011) ? K_SUBU :
                    (op == 6'b000000 && funct == 6'b001000) ? K_JR   :
                    (op == 6'b001101) ? K_ORI :
                    (op == 6'b001111) ? K_LUI :
                    (op == 6'b100011) ? K_LW  :
                    (op == 6'b101011) ? K_SW  :
                    (op == 6'b000100) ? K_BEQ :
                    (op == 6'b000010) ? K_J   :
                    (op == 6'b000011) ? K_JAL : K_ILL;
    always_comb begin
        state_d = FETCH;
        {PCWrite, PCSel, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg} = '0;
        {ALUSrcA, ALUSrcB, ExtOp, ALUControl, instr_done, illegal} = '0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ExtOp      = 1'b1;
                illegal    = kind_d == K_ILL;
                instr_done = kind_d == K_ILL;
                state_d    = (kind_d == K_LW || kind_d == K_SW) ? MEMADR :
                             (kind_d == K_ADDU || kind_d == K_SUBU) ? EXEC_R :
                             (kind_d == K_ORI || kind_d == K_LUI) ? EXEC_I :
                             (kind_d == K_BEQ) ? BRANCH :
                             (kind_d == K_J || kind_d == K_JAL || kind_d == K_JR) ? JUMP : FETCH;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                state_d = kind_q == K_SW ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUControl = kind_q == K_SUBU ? 3'b001 : 3'b000;
                state_d    = RWB;
            end
            RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = kind_q == K_LUI ? 3'b011 : 3'b010;
                state_d    = IWB;
            end
            IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b001;
                PCSel      = 2'b01;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSel      = kind_q == K_JR ? 2'b11 : 2'b10;
                RegWrite   = kind_q == K_JAL;
                RegDst     = kind_q == K_JAL ? 2'b10 : 2'b00;
                MemtoReg   = kind_q == K_JAL ? 2'b10 : 2'b00;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        retired_d = retired_q + (instr_done ? 32'd1 : 32'd0);
        if (reset) begin
            {PCWrite, PCSel, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg} = '0;
            {ALUSrcA, ALUSrcB, ExtOp, ALUControl, instr_done, illegal} = '0;
        end
    end
    always_ff @(posedge clk) begin
        state_q   <= reset ? FETCH : state_d;
        kind_q    <= reset ? K_ILL : (state_q == DECODE ? kind_d : kind_q);
        retired_q <= reset ? 32'd0 : retired_d;
    end
    assign state   = reset ? 4'd0 : state_q;
    assign retired = reset ? 32'd0 : retired_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench against a per-instruction cycle model
module tb_mc_controller;
    localparam int ADDU = 0, SUBU = 1, JR = 2, ORI = 3, LUI = 4, LW = 5, SW = 6, BEQ = 7, J = 8, JAL = 9, ILL = 10;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = '0, funct = '0;
    logic        zero = 1'b0;
    logic        PCWrite, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtOp, instr_done, illegal;
    logic [1:0]  PCSel, RegDst, MemtoReg, ALUSrcB;
    logic [2:0]  ALUControl;
    logic [3:0]  state;
    logic [31:0] retired;
    logic [23:0] got;
    logic [31:0] exp_ret = '0;
    int          vectors = 0, miscompares = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCWrite(PCWrite), .PCSel(PCSel), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUControl(ALUControl), .state(state),
        .instr_done(instr_done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, PCSel, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                  ALUSrcA, ALUSrcB, ExtOp, ALUControl, state, instr_done, illegal};

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) return f == 6'b100001 ? ADDU : f == 6'b100011 ? SUBU : f == 6'b001000 ? JR : ILL;
        case (o)
            6'b001101: return ORI;
            6'b001111: return LUI;
            6'b100011: return LW;
            6'b101011: return SW;
            6'b000100: return BEQ;
            6'b000010: return J;
            6'b000011: return JAL;
            default:   return ILL;
        endcase
    endfunction

    function automatic logic [11:0] enc(input int k);
        case (k)
            ADDU:    return {6'b000000, 6'b100001};
            SUBU:    return {6'b000000, 6'b100011};
            JR:      return {6'b000000, 6'b001000};
            ORI:     return {6'b001101, 6'($urandom)};
            LUI:     return {6'b001111, 6'($urandom)};
            LW:      return {6'b100011, 6'($urandom)};
            SW:      return {6'b101011, 6'($urandom)};
            BEQ:     return {6'b000100, 6'($urandom)};
            J:       return {6'b000010, 6'($urandom)};
            JAL:     return {6'b000011, 6'($urandom)};
            default: return {6'b111111, 6'b000000};
        endcase
    endfunction

    function automatic int cpi(input int k);
        if (k == LW) return 5;
        if (k == SW || k == ADDU || k == SUBU || k == ORI || k == LUI) return 4;
        return k == ILL ? 2 : 3;
    endfunction

    // Expected output vector for cycle c (0 = fetch) of an instruction of kind k.
    function automatic logic [23:0] expv(input int k, input int c, input logic z);
        logic pcw, iord, mw, irw, rw, srca, ext, done, ill;
        logic [1:0] pcs, rdst, m2r, srcb;
        logic [2:0] alu;
        logic [3:0] st;
        bit mem, rt, it, jmp;
        mem = k == LW || k == SW;
        rt  = k == ADDU || k == SUBU;
        it  = k == ORI || k == LUI;
        jmp = k == J || k == JAL || k == JR;
        {pcw, iord, mw, irw, rw, srca, ext, done, ill, pcs, rdst, m2r, srcb, alu, st} = '0;
        if (c == 0) begin
            pcw = 1; irw = 1; srcb = 2'b01;
        end else if (c == 1) begin
            st = 1; srcb = 2'b11; ext = 1; ill = k == ILL; done = k == ILL;
        end else if (c == 2) begin
            if (mem) begin st = 2; srca = 1; srcb = 2'b10; ext = 1; end
            else if (rt) begin st = 6; srca = 1; alu = k == SUBU ? 3'b001 : 3'b000; end
            else if (it) begin st = 8; srca = 1; srcb = 2'b10; alu = k == LUI ? 3'b011 : 3'b010; end
            else if (k == BEQ) begin st = 10; srca = 1; alu = 3'b001; pcs = 2'b01; pcw = z; done = 1; end
            else if (jmp) begin
                st = 11; pcw = 1; pcs = k == JR ? 2'b11 : 2'b10; done = 1;
                rw = k == JAL; rdst = k == JAL ? 2'b10 : 2'b00; m2r = k == JAL ? 2'b10 : 2'b00;
            end
        end else if (c == 3) begin
            if (k == LW) begin st = 3; iord = 1; end
            else if (k == SW) begin st = 5; iord = 1; mw = 1; done = 1; end
            else if (rt) begin st = 7; rw = 1; rdst = 2'b01; done = 1; end
            else begin st = 9; rw = 1; done = 1; end
        end else begin
            st = 4; rw = 1; m2r = 2'b01; done = 1;
        end
        return {pcw, pcs, iord, mw, irw, rw, rdst, m2r, srca, srcb, ext, alu, st, done, ill};
    endfunction

    // zmode < 0 drives a random zero each cycle; abort_at asserts reset in that cycle;
    // rel_at releases a forced retired counter in that cycle.
    task automatic run_instr(input logic [11:0] ins, input int zmode, input int abort_at, input int rel_at);
        int k;
        logic [23:0] e;
        k = classify(ins[11:6], ins[5:0]);
        for (int c = 0; c < cpi(k); c++) begin
            @(negedge clk);
            reset = c == abort_at;
            if (c == rel_at) release dut.retired_q;
            op = ins[11:6];
            funct = ins[5:0];
            zero = zmode < 0 ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            e = c == abort_at ? 24'd0 : expv(k, c, zero);
            if (c == abort_at) exp_ret = '0;
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL outputs op=%b funct=%b cyc %0d: got %h, required %h", op, funct, c, got, e);
            end
            vectors++;
            if (retired !== exp_ret) begin
                miscompares++;
                $display("FAIL retired op=%b cyc %0d: got %h, required %h", op, c, retired, exp_ret);
            end
            if (c == abort_at) break;
            if (e[1]) exp_ret++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 6'($urandom);
            funct = 6'($urandom);
            zero = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (got !== 24'd0 || retired !== 32'd0) begin
                miscompares++;
                $display("FAIL reset cyc %0d: outputs %h retired %h, required 0 and 0", i, got, retired);
            end
        end
    endtask

    task automatic test_lw();
        run_instr(enc(LW), -1, -1, -1);
    endtask

    task automatic test_beq();
        run_instr(enc(BEQ), 1, -1, -1);
        run_instr(enc(BEQ), 0, -1, -1);
    endtask

    task automatic test_jumps();
        run_instr(enc(JAL), -1, -1, -1);
        run_instr(enc(JR), -1, -1, -1);
        run_instr(enc(J), -1, -1, -1);
    endtask

    task automatic test_illegal();
        run_instr({6'b111111, 6'b000000}, -1, -1, -1);
        run_instr({6'b000000, 6'b100000}, -1, -1, -1);
    endtask

    task automatic test_mid_reset();
        run_instr(enc(SW), -1, 3, -1);
        run_instr(enc(ORI), -1, -1, -1);
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        exp_ret = 32'hFFFF_FFFF;
        run_instr(enc(ADDU), -1, -1, 3);
        run_instr(enc(LUI), -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        logic [11:0] ins;
        for (int n = 0; n < 80; n++) begin
            ins = enc($urandom_range(0, 10));
            if (classify(ins[11:6], ins[5:0]) == ILL) ins = 12'($urandom);
            run_instr(ins, -1, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_beq();
        test_jumps();
        test_illegal();
        test_mid_reset();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the next-generation MIPS core: a Moore/Mealy FSM that sequences a shared-memory, single-ALU datapath (PC, IR, MDR, A/B, ALUOut registers) over several cycles per instruction. It replaces the single-cycle combinational controller. It decodes `op`/`funct` from the instruction register, steers the datapath muxes and enables state by state, and counts retired instructions.

## Interface
No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational from the datapath.
- `PCWrite` out 1: PC load enable.
- `PCSel` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}, 11 = register A.
- `IorD` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data store enable.
- `IRWrite` out 1: IR load enable.
- `RegWrite` out 1: GRF write enable.
- `RegDst` out 2: write address. 00 = rt, 01 = rd, 10 = 5'd31.
- `MemtoReg` out 2: write data. 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 32'd4, 10 = extended imm, 11 = SignImm<<2.
- `ExtOp` out 1: 0 = zero-extend, 1 = sign-extend.
- `ALUControl` out 3: 000 = add, 001 = sub, 010 = or, 011 = B<<16.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `retired` out 32: count of retired instructions.

## Operation
- Supported instructions: addu (R, funct 100001), subu (R, 100011), jr (R, 001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010), jal (000011). Any other op/funct is illegal and executes as a nop.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JUMP=11.
- Any output not listed for a state is 0. ALUControl defaults to 000.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, add, PCWrite=1, PCSel=00. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, add, so ALUOut gets the branch target.
- DECODE next state by instruction:
  - lw, sw → MEMADR.
  - addu, subu → EXEC_R.
  - ori, lui → EXEC_I.
  - beq → BRANCH.
  - j, jal, jr → JUMP.
  - illegal → FETCH, with `illegal` and `instr_done` both pulsed.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1 (MDR loads). Next state MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1. Next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, add for addu or sub for subu. Next state RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00. Next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtOp=0. ALUControl is or for ori, 011 for lui. Next state IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSel=01, PCWrite = `zero`. This is the only Mealy output. Next state FETCH.
- JUMP:
  - j: PCWrite=1, PCSel=10.
  - jal: PCWrite=1, PCSel=10, plus RegWrite=1, RegDst=10, MemtoReg=10. The PC already holds PC+4, and the GRF write samples PC before the PC update at the same edge.
  - jr: PCWrite=1, PCSel=11.
  - Next state FETCH.
- `instr_done`=1 in MEMWB, MEMWR, RWB, IWB, BRANCH and JUMP, and in DECODE when the opcode is illegal.
- `retired` increments by 1 at each clock edge where `instr_done`=1. It is 32-bit and wraps from 0xFFFFFFFF to 0.

## Timing
- Cycles per instruction: lw 5; sw, addu, subu, ori, lui 4; beq, j, jal, jr 3; illegal 2.
- `op`/`funct` are sampled only in DECODE and MEMADR. IR is stable from FETCH+1 onward.
- Reset (synchronous): at the edge where `reset`=1, state←FETCH and retired←0.
- While `reset` is high, all outputs are forced to 0 regardless of state: every enable, mux select, `instr_done` and `illegal`. `state` reads 0 and `retired` reads 0.
- The first FETCH executes in the first cycle with `reset` low.
- Reset asserted mid-instruction abandons it: no register write or memory write occurs in that cycle, and `retired` is not incremented.
- `zero` must settle within the BRANCH cycle. There is no other combinational input-to-output path.

## Test plan
- Reset, then lw: states 0,1,2,3,4. MemWrite is never 1. Cycle 5 has RegWrite=1, RegDst=00, MemtoReg=01. `retired` reads 1 after that edge.
- beq with zero=1 in BRANCH → PCWrite=1, PCSel=01. Repeat with zero=0 → PCWrite=0. Both take 3 cycles and both pulse `instr_done`.
- jal (op 000011) → JUMP cycle has PCWrite=1, PCSel=10, RegWrite=1, RegDst=10, MemtoReg=10. jr (op 0, funct 001000) → PCSel=11, RegWrite=0.
- op 111111 → DECODE pulses `illegal`=1 and `instr_done`=1, next state FETCH, no RegWrite or MemWrite at any point, `retired` +1.
- Reset asserted in MEMWR of an sw → MemWrite=0 in that cycle, state=0 next cycle, `retired`=0.
- Force `retired` to 0xFFFFFFFF, run addu (4 cycles, RegDst=01) → `retired` = 0.
